// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DefXlen  = 32;
    localparam int unsigned DefNregs = 32;
    localparam int unsigned DefAw    = $clog2(DefNregs);

    typedef logic [DefAw-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = DefNregs,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NWR-1:0]         we_i,
    input  logic [NWR-1:0][AW-1:0] wa_i,
    input  logic                   issue_valid_i,
    input  logic [AW-1:0]          issue_rd_i,
    output logic                   issue_ready_o,
    output logic [NREGS-1:0]       busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        issue_ready_o = !busy_q[issue_rd_i] || (issue_rd_i == '0);
    end

    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (we_i[w]) begin
                busy_d[wa_i[w]] = 1'b0;
            end
        end
        // Applied after the clears so a same-cycle issue keeps the bit set.
        if (issue_valid_i && issue_ready_o && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with x0 hardwired to zero and a busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = DefXlen,
    parameter int unsigned NREGS = DefNregs,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NRD-1:0][AW-1:0]   ra,
    output logic [NRD-1:0][XLEN-1:0] rd,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           we,
    input  logic [NWR-1:0][AW-1:0]   wa,
    input  logic [NWR-1:0][XLEN-1:0] wd,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    output logic                     issue_ready
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk_i         (clk),
        .rst_ni        (reset_n),
        .we_i          (we),
        .wa_i          (wa),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .busy_o        (busy)
    );

    // Ascending port order lets the highest-index writer win on address conflicts.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NWR; w++) begin
            if (we[w] && (wa[w] != '0)) begin
                regs_d[wa[w]] = wd[w];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Outputs are gated during reset so bypassed write data cannot leak out.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd[i]      = '0;
            rd_busy[i] = 1'b0;
            if (reset_n && (ra[i] != '0)) begin
                rd[i]      = regs_q[ra[i]];
                rd_busy[i] = busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (we[w] && (wa[w] == ra[i])) begin
                        rd[i]      = wd[w];
                        rd_busy[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers, power of two, at least 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ra, input, NRD x AW: read addresses.
REQ-008 SHALL have port rd, output, NRD x XLEN: read data.
REQ-009 SHALL have port rd_busy, output, NRD bits: the addressed register has a pending write.
REQ-010 SHALL have port we, input, NWR bits: write enables.
REQ-011 SHALL have port wa, input, NWR x AW: write addresses.
REQ-012 SHALL have port wd, input, NWR x XLEN: write data.
REQ-013 SHALL have port issue_valid, input, 1 bit: request to reserve a destination register.
REQ-014 SHALL have port issue_rd, input, AW bits: the destination to reserve.
REQ-015 SHALL have port issue_ready, output, 1 bit: the reservation is accepted this cycle.

Function
REQ-016 SHALL read combinationally: rd[i] = reg[ra[i]] in the same cycle.
REQ-017 SHALL always read register 0 as 0, ignore writes to it, and never mark it busy.
REQ-018 SHALL perform writes on the rising clock edge; without bypass, written data is visible on rd from the next cycle.
REQ-019 SHALL resolve same-cycle writes to the same address in favour of the highest-index port; lower-index writes to that address are dropped.
REQ-020 SHALL keep a scoreboard of NREGS busy bits: a bit is set on an accepted issue (issue_valid and issue_ready) and cleared on any enabled write to that address.
REQ-021 SHALL drive issue_ready = !busy[issue_rd] or (issue_rd == 0); issue_ready is combinational.
REQ-022 SHALL accept issue to register 0 with no effect on the scoreboard.
REQ-023 SHALL leave a busy bit set when an accepted issue and a write hit the same register in the same cycle (the issue wins).
REQ-024 SHALL drive rd_busy[i] = busy[ra[i]], except that when REGFILE_BYPASS_EN is defined and ra[i] is being written this cycle, rd_busy[i] = 0.
REQ-025 SHALL make issue_valid with issue_ready low a stall with no state change; the requester holds its request.

Reset
REQ-026 SHALL asynchronously clear all registers to 0 and all busy bits to 0 when reset_n is low.
REQ-027 SHALL drive rd = 0, rd_busy = 0 and issue_ready = 1 during reset, whatever the inputs.
REQ-028 SHALL drop any write or issue in the cycle that reset asserts; operation resumes on the first rising edge after deassertion.

Configuration
REQ-029 SHALL implement write-to-read bypass when REGFILE_BYPASS_EN is defined: if ra[i] is nonzero and matches an enabled write this cycle, rd[i] returns that wd, with highest-index priority per REQ-019.
REQ-030 SHALL, without REGFILE_BYPASS_EN, return the pre-edge stored value on a read that coincides with a write to the same register.

Structure
REQ-031 SHALL place default XLEN and NREGS constants and the register-address typedef in package regfile_pkg.
REQ-032 SHALL implement the busy-bit array, issue_ready and the set/clear logic in sub-module regfile_scoreboard; the data array and bypass logic stay in regfile_sb.

Verification
REQ-033 SHALL check reset: assert reset_n low mid-run after writing x5 = 0xA5A5A5A5 -> ra = {5,0} reads 0,0; rd_busy = 0; issue_ready = 1.
REQ-034 SHALL check x0: we[0] = 1, wa = 0, wd = 0xDEADBEEF, plus issue_rd = 0 -> x0 reads 0; issue_ready stays 1.
REQ-035 SHALL check dual-write conflict: port0 writes x3 = 0x11112222 and port1 writes x3 = 0x33334444 in the same cycle -> x3 reads 0x33334444 next cycle.
REQ-036 SHALL check scoreboard: issue x7 -> rd_busy = 1 for ra = 7; a second issue to x7 -> issue_ready = 0; write x7 = 0x5 -> next cycle rd_busy = 0 and issue_ready = 1.
REQ-037 SHALL check simultaneous issue and write to x9 -> x9 stays busy with data = the written value.
REQ-038 SHALL check bypass: write x4 = 0xCAFEF00D while ra[0] = 4 -> with the macro, rd = 0xCAFEF00D in the same cycle; without it, rd = the old value.
